ddr_line_read_master: RTL and testbench

//  AXI4 read master feeding the display-side line FIFO. Each request fetches one full video line of H_DISP

---
 rtl/video_ddr_pkg.sv | 31 +++
 rtl/axi_4k_burst_split.sv | 44 ++++
 rtl/ddr_line_read_master.sv | 197 +++++++++++++++++++
 tb/tb_ddr_line_read_master.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_ddr_pkg.sv
// ----------------------------------------------------------------------------
// video_ddr_pkg
//   Shared constants and helpers for the DDR video masters.
//   - PAGE_4K                : AXI 4 KB address boundary that no burst may cross
//   - ST_IDLE/ST_ADDR/ST_DATA: read-master FSM state encoding
//   - bytes_per_beat()       : bytes carried by one data beat
//   - beats_per_line()       : data beats per video line (32-bit pixels)
//   - axi_size()             : AxSIZE encoding for a given data width
// ----------------------------------------------------------------------------
package video_ddr_pkg;

   localparam int unsigned PAGE_4K = 4096;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   function automatic int unsigned bytes_per_beat(input int unsigned dw);
      return dw / 8;
   endfunction

   function automatic int unsigned beats_per_line(input int unsigned h_disp,
                                                  input int unsigned dw);
      return (h_disp * 32) / dw;
   endfunction

   function automatic logic [2:0] axi_size(input int unsigned dw);
      return 3'($clog2(dw / 8));
   endfunction

endpackage

// File: rtl/axi_4k_burst_split.sv
// ----------------------------------------------------------------------------
// axi_4k_burst_split
//   Combinational burst sizer: picks the largest burst that fits the remaining
//   beat count, the maximum burst length and the room left in the current
//   4 KB page.
// Ports
//   i_page_offset [11:0] : cur_addr[11:0], byte offset inside the 4 KB page
//   i_beats_left  [15:0] : beats still to be requested
//   o_len         [8:0]  : beats for the next burst (ARLEN = o_len-1)
// ----------------------------------------------------------------------------
module axi_4k_burst_split
   import video_ddr_pkg::*;
#(
   parameter int unsigned AXI4_DATA_WIDTH = 128,
   parameter int unsigned BURST_LEN       = 64
) (
   input  logic [11:0] i_page_offset,
   input  logic [15:0] i_beats_left,
   output logic [8:0]  o_len
);

   localparam int unsigned BPB = bytes_per_beat(AXI4_DATA_WIDTH);

   logic [12:0] w_room_bytes;
   logic [12:0] w_room_beats;
   logic [8:0]  w_cap;

   always_comb begin
      w_room_bytes = 13'(PAGE_4K) - {1'b0, i_page_offset};
      w_room_beats = w_room_bytes / 13'(BPB);
      // Page room and BURST_LEN are both <= 256 after capping, so 9 bits suffice.
      if (w_room_beats > 13'(BURST_LEN)) begin
         w_cap = 9'(BURST_LEN);
      end else begin
         w_cap = w_room_beats[8:0];
      end
      if (i_beats_left < {7'b0, w_cap}) begin
         o_len = i_beats_left[8:0];
      end else begin
         o_len = w_cap;
      end
   end

endmodule

// File: rtl/ddr_line_read_master.sv
// ----------------------------------------------------------------------------
// ddr_line_read_master
//   AXI4 read master that fetches one full video line per request from DDR and
//   streams it into the display-side line FIFO (one 32-bit pixel per lane).
// Ports
//   M_AXI_ACLK / M_AXI_ARESETN          : clock, synchronous active-low reset
//   AXI_FULL_BURST_VALID / _READY       : line-fetch request handshake
//   fifo_rst_n                          : frame restart (active low)
//   fifo_prog_full                      : FIFO cannot take another full burst
//   fifo_wr_en / fifo_wr_data           : FIFO write port (RDATA pass-through)
//   M_AXI_AR*                           : read address channel
//   M_AXI_R*                            : read data channel
//   line_idx                            : line of the next/current fetch
//   rd_err                              : sticky error (bad RRESP or RLAST)
// ----------------------------------------------------------------------------
module ddr_line_read_master
   import video_ddr_pkg::*;
#(
   parameter int unsigned AXI4_DATA_WIDTH = 128,
   parameter int unsigned AXI4_ADDR_WIDTH = 32,
   parameter int unsigned H_DISP          = 1920,
   parameter int unsigned V_DISP          = 1080,
   parameter int unsigned BURST_LEN       = 64,
   parameter logic [AXI4_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = '0,
   parameter int unsigned LINE_STRIDE     = H_DISP * 4
) (
   input  logic                         M_AXI_ACLK,
   input  logic                         M_AXI_ARESETN,
   input  logic                         AXI_FULL_BURST_VALID,
   output logic                         AXI_FULL_BURST_READY,
   input  logic                         fifo_rst_n,
   input  logic                         fifo_prog_full,
   output logic                         fifo_wr_en,
   output logic [AXI4_DATA_WIDTH-1:0]   fifo_wr_data,
   output logic [AXI4_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [7:0]                   M_AXI_ARLEN,
   output logic [2:0]                   M_AXI_ARSIZE,
   output logic [1:0]                   M_AXI_ARBURST,
   output logic                         M_AXI_ARVALID,
   input  logic                         M_AXI_ARREADY,
   input  logic [AXI4_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                   M_AXI_RRESP,
   input  logic                         M_AXI_RLAST,
   input  logic                         M_AXI_RVALID,
   output logic                         M_AXI_RREADY,
   output logic [10:0]                  line_idx,
   output logic                         rd_err
);

   localparam int unsigned BPB          = bytes_per_beat(AXI4_DATA_WIDTH);
   localparam logic [15:0] LINE_BEATS   = 16'(beats_per_line(H_DISP, AXI4_DATA_WIDTH));
   localparam logic [10:0] LAST_LINE    = 11'(V_DISP - 1);

   logic [1:0]                 r_state;
   logic                       r_arvalid;
   logic [AXI4_ADDR_WIDTH-1:0] r_araddr;
   logic [7:0]                 r_arlen;
   logic [8:0]                 r_burst_len;
   logic [8:0]                 r_beat_cnt;
   logic [AXI4_ADDR_WIDTH-1:0] r_cur_addr;
   logic [15:0]                r_beats_left;
   logic [AXI4_ADDR_WIDTH-1:0] r_line_base;
   logic [10:0]                r_line_idx;
   logic                       r_drop;
   logic                       r_rd_err;

   logic [8:0]                 w_len;
   logic                       w_ready;
   logic                       w_r_hs;
   logic                       w_last_expected;
   logic [AXI4_ADDR_WIDTH-1:0] w_burst_bytes;

   axi_4k_burst_split #(
      .AXI4_DATA_WIDTH (AXI4_DATA_WIDTH),
      .BURST_LEN       (BURST_LEN)
   ) u_split (
      .i_page_offset (r_cur_addr[11:0]),
      .i_beats_left  (r_beats_left),
      .o_len         (w_len)
   );

   assign w_ready         = (r_state == ST_IDLE) && fifo_rst_n && M_AXI_ARESETN;
   assign w_r_hs          = M_AXI_RVALID && (r_state == ST_DATA);
   assign w_last_expected = (r_beat_cnt == (r_burst_len - 9'd1));
   assign w_burst_bytes   = AXI4_ADDR_WIDTH'(r_burst_len) * AXI4_ADDR_WIDTH'(BPB);

   assign AXI_FULL_BURST_READY = w_ready;
   assign M_AXI_ARADDR         = r_araddr;
   assign M_AXI_ARLEN          = r_arlen;
   assign M_AXI_ARSIZE         = axi_size(AXI4_DATA_WIDTH);
   assign M_AXI_ARBURST        = 2'b01;
   assign M_AXI_ARVALID        = r_arvalid;
   assign M_AXI_RREADY         = (r_state == ST_DATA);
   // The restart cycle itself is already gated so no beat slips into the
   // freshly reset FIFO before r_drop takes effect.
   assign fifo_wr_en           = w_r_hs && !r_drop && fifo_rst_n;
   assign fifo_wr_data         = M_AXI_RDATA;
   assign line_idx             = r_line_idx;
   assign rd_err               = r_rd_err;

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         r_state      <= ST_IDLE;
         r_arvalid    <= 1'b0;
         r_araddr     <= '0;
         r_arlen      <= '0;
         r_burst_len  <= '0;
         r_beat_cnt   <= '0;
         r_cur_addr   <= FRAME_BASE_ADDR;
         r_beats_left <= '0;
         r_line_base  <= FRAME_BASE_ADDR;
         r_line_idx   <= '0;
         r_drop       <= 1'b0;
         r_rd_err     <= 1'b0;
      end else begin
         if (w_r_hs) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
            if (M_AXI_RRESP != 2'b00) begin
               r_rd_err <= 1'b1;
            end
            // Early RLAST, or a missing RLAST on the expected last beat.
            if (M_AXI_RLAST != w_last_expected) begin
               r_rd_err <= 1'b1;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (w_ready && AXI_FULL_BURST_VALID) begin
                  r_cur_addr   <= r_line_base;
                  r_beats_left <= LINE_BEATS;
                  r_state      <= ST_ADDR;
               end
            end

            ST_ADDR: begin
               if (!r_arvalid) begin
                  if (!fifo_rst_n) begin
                     r_state <= ST_IDLE;
                  end else if (!fifo_prog_full) begin
                     // Address and length are frozen here until ARREADY.
                     r_arvalid   <= 1'b1;
                     r_araddr    <= r_cur_addr;
                     r_arlen     <= 8'(w_len - 9'd1);
                     r_burst_len <= w_len;
                  end
               end else begin
                  if (!fifo_rst_n) begin
                     r_drop <= 1'b1;
                  end
                  if (M_AXI_ARREADY) begin
                     r_arvalid    <= 1'b0;
                     r_cur_addr   <= r_cur_addr + w_burst_bytes;
                     r_beats_left <= r_beats_left - 16'(r_burst_len);
                     r_beat_cnt   <= '0;
                     r_state      <= ST_DATA;
                  end
               end
            end

            ST_DATA: begin
               if (!fifo_rst_n) begin
                  r_drop <= 1'b1;
               end
               if (w_r_hs && M_AXI_RLAST) begin
                  if (r_drop || !fifo_rst_n) begin
                     r_drop  <= 1'b0;
                     r_state <= ST_IDLE;
                  end else if (r_beats_left != 16'd0) begin
                     r_state <= ST_ADDR;
                  end else begin
                     if (r_line_idx == LAST_LINE) begin
                        r_line_idx  <= '0;
                        r_line_base <= FRAME_BASE_ADDR;
                     end else begin
                        r_line_idx  <= r_line_idx + 11'd1;
                        r_line_base <= r_line_base + AXI4_ADDR_WIDTH'(LINE_STRIDE);
                     end
                     r_state <= ST_IDLE;
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase

         // Frame restart overrides any line advance taken in the same cycle.
         if (!fifo_rst_n) begin
            r_line_idx  <= '0;
            r_line_base <= FRAME_BASE_ADDR;
         end
      end
   end

endmodule

// File: tb/tb_ddr_line_read_master.sv
// ----------------------------------------------------------------------------
// tb_ddr_line_read_master
//   Directed bench for ddr_line_read_master with a small AXI read slave whose
//   RDATA carries the beat byte address, so FIFO contents reveal addressing.
// ----------------------------------------------------------------------------
module tb_ddr_line_read_master;

   localparam int unsigned DW = 128;
   localparam int unsigned AW = 32;

   logic          clk;
   logic          M_AXI_ARESETN;
   logic          AXI_FULL_BURST_VALID;
   logic          AXI_FULL_BURST_READY;
   logic          fifo_rst_n;
   logic          fifo_prog_full;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_wr_data;
   logic [AW-1:0] M_AXI_ARADDR;
   logic [7:0]    M_AXI_ARLEN;
   logic [2:0]    M_AXI_ARSIZE;
   logic [1:0]    M_AXI_ARBURST;
   logic          M_AXI_ARVALID;
   logic          M_AXI_ARREADY;
   logic [DW-1:0] M_AXI_RDATA;
   logic [1:0]    M_AXI_RRESP;
   logic          M_AXI_RLAST;
   logic          M_AXI_RVALID;
   logic          M_AXI_RREADY;
   logic [10:0]   line_idx;
   logic          rd_err;

   int checks = 0;
   int errors = 0;

   // slave state
   logic          sl_busy;
   logic [31:0]   sl_addr;
   logic [7:0]    sl_len;
   logic [7:0]    sl_beat;
   logic          err_en;
   logic [31:0]   err_addr;

   // monitor state
   logic [31:0]   ar_addr_q[$];
   logic [7:0]    ar_len_q[$];
   int            wr_count;
   int            data_err;
   logic [31:0]   exp_addr;

   ddr_line_read_master #(
      .AXI4_DATA_WIDTH (128),
      .AXI4_ADDR_WIDTH (32),
      .H_DISP          (1920),
      .V_DISP          (4),
      .BURST_LEN       (64),
      .FRAME_BASE_ADDR (32'h0),
      .LINE_STRIDE     (7680)
   ) dut (
      .M_AXI_ACLK           (clk),
      .M_AXI_ARESETN        (M_AXI_ARESETN),
      .AXI_FULL_BURST_VALID (AXI_FULL_BURST_VALID),
      .AXI_FULL_BURST_READY (AXI_FULL_BURST_READY),
      .fifo_rst_n           (fifo_rst_n),
      .fifo_prog_full       (fifo_prog_full),
      .fifo_wr_en           (fifo_wr_en),
      .fifo_wr_data         (fifo_wr_data),
      .M_AXI_ARADDR         (M_AXI_ARADDR),
      .M_AXI_ARLEN          (M_AXI_ARLEN),
      .M_AXI_ARSIZE         (M_AXI_ARSIZE),
      .M_AXI_ARBURST        (M_AXI_ARBURST),
      .M_AXI_ARVALID        (M_AXI_ARVALID),
      .M_AXI_ARREADY        (M_AXI_ARREADY),
      .M_AXI_RDATA          (M_AXI_RDATA),
      .M_AXI_RRESP          (M_AXI_RRESP),
      .M_AXI_RLAST          (M_AXI_RLAST),
      .M_AXI_RVALID         (M_AXI_RVALID),
      .M_AXI_RREADY         (M_AXI_RREADY),
      .line_idx             (line_idx),
      .rd_err               (rd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // AXI read slave: one burst at a time, RVALID every cycle while busy.
   initial begin : slave
      logic        s_ar_hs;
      logic        s_r_hs;
      logic        s_rst;
      logic [31:0] s_araddr;
      logic [7:0]  s_arlen;
      logic [31:0] beat_addr;
      sl_busy = 1'b0; sl_addr = '0; sl_len = '0; sl_beat = '0;
      M_AXI_ARREADY = 1'b1;
      M_AXI_RVALID  = 1'b0;
      M_AXI_RLAST   = 1'b0;
      M_AXI_RDATA   = '0;
      M_AXI_RRESP   = 2'b00;
      forever begin
         @(negedge clk);
         s_rst    = !M_AXI_ARESETN;
         s_ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
         s_r_hs   = M_AXI_RVALID && M_AXI_RREADY;
         s_araddr = M_AXI_ARADDR;
         s_arlen  = M_AXI_ARLEN;
         @(posedge clk);
         #1;
         if (s_rst) begin
            sl_busy = 1'b0;
         end else begin
            if (s_r_hs) begin
               if (sl_beat == sl_len) sl_busy = 1'b0;
               else sl_beat = sl_beat + 8'd1;
            end
            if (s_ar_hs) begin
               sl_busy = 1'b1;
               sl_addr = s_araddr;
               sl_len  = s_arlen;
               sl_beat = '0;
            end
         end
         beat_addr    = sl_addr + 32'(sl_beat) * 32'd16;
         M_AXI_RVALID = sl_busy;
         M_AXI_RLAST  = sl_busy && (sl_beat == sl_len);
         M_AXI_RDATA  = {4{beat_addr}};
         M_AXI_RRESP  = (err_en && sl_busy && beat_addr == err_addr) ? 2'b10 : 2'b00;
      end
   end

   // Monitor: log AR handshakes and check FIFO data against expected addresses.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            ar_addr_q.push_back(M_AXI_ARADDR);
            ar_len_q.push_back(M_AXI_ARLEN);
         end
         if (fifo_wr_en) begin
            wr_count = wr_count + 1;
            if (fifo_wr_data !== {4{exp_addr}}) data_err = data_err + 1;
            exp_addr = exp_addr + 32'd16;
         end
      end
   end

   task automatic clear_log(input logic [31:0] base);
      ar_addr_q.delete();
      ar_len_q.delete();
      wr_count = 0;
      data_err = 0;
      exp_addr = base;
   endtask

   task automatic do_request();
      bit ok = 0;
      AXI_FULL_BURST_VALID = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (AXI_FULL_BURST_READY) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      AXI_FULL_BURST_VALID = 1'b0;
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL request_accept: got %0b expected 1", ok);
      end
   endtask

   task automatic wait_line_done();
      bit done = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (wr_count >= 480 && AXI_FULL_BURST_READY && !sl_busy) begin
            done = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL line_done_timeout: writes %0d expected 480", wr_count);
      end
   endtask

   task automatic check_line_data();
      checks++;
      if (wr_count !== 480) begin
         errors++;
         $display("FAIL wr_count: got %0d expected 480", wr_count);
      end
      checks++;
      if (data_err !== 0) begin
         errors++;
         $display("FAIL wr_data: got %0d bad beats expected 0", data_err);
      end
      checks++;
      if (ar_addr_q.size() !== 8) begin
         errors++;
         $display("FAIL burst_count: got %0d expected 8", ar_addr_q.size());
      end
   endtask

   task automatic test_reset();
      M_AXI_ARESETN = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({AXI_FULL_BURST_READY, M_AXI_ARVALID, M_AXI_RREADY, fifo_wr_en, rd_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {AXI_FULL_BURST_READY, M_AXI_ARVALID, M_AXI_RREADY, fifo_wr_en, rd_err});
      end
      checks++;
      if (line_idx !== 11'd0) begin
         errors++;
         $display("FAIL reset_line_idx: got %0d expected 0", line_idx);
      end
      checks++;
      if ({M_AXI_ARSIZE, M_AXI_ARBURST} !== {3'd4, 2'b01}) begin
         errors++;
         $display("FAIL ar_const: got size %0d burst %0d expected 4 1", M_AXI_ARSIZE, M_AXI_ARBURST);
      end
      @(posedge clk);
      #1;
      M_AXI_ARESETN = 1'b1;
      @(negedge clk);
      checks++;
      if (AXI_FULL_BURST_READY !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b expected 1", AXI_FULL_BURST_READY);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_line0();
      clear_log(32'h0);
      do_request();
      wait_line_done();
      check_line_data();
      if (ar_addr_q.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            logic [31:0] ea;
            logic [7:0]  el;
            ea = 32'(i) * 32'h400;
            el = (i == 7) ? 8'd31 : 8'd63;
            checks++;
            if (ar_addr_q[i] !== ea || ar_len_q[i] !== el) begin
               errors++;
               $display("FAIL line0_burst%0d: got %h/%0d expected %h/%0d", i, ar_addr_q[i], ar_len_q[i], ea, el);
            end
         end
      end
      checks++;
      if (line_idx !== 11'd1) begin
         errors++;
         $display("FAIL line0_idx: got %0d expected 1", line_idx);
      end
   endtask

   task automatic test_4k_split();
      clear_log(32'h1E00);
      do_request();
      wait_line_done();
      check_line_data();
      if (ar_addr_q.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            logic [31:0] ea;
            logic [7:0]  el;
            ea = (i == 0) ? 32'h1E00 : 32'h2000 + 32'(i - 1) * 32'h400;
            el = (i == 0) ? 8'd31 : 8'd63;
            checks++;
            if (ar_addr_q[i] !== ea || ar_len_q[i] !== el) begin
               errors++;
               $display("FAIL line1_burst%0d: got %h/%0d expected %h/%0d", i, ar_addr_q[i], ar_len_q[i], ea, el);
            end
         end
      end
      checks++;
      if (line_idx !== 11'd2) begin
         errors++;
         $display("FAIL line1_idx: got %0d expected 2", line_idx);
      end
   endtask

   task automatic test_prog_full();
      int seen = 0;
      clear_log(32'h3C00);
      fifo_prog_full = 1'b1;
      do_request();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (M_AXI_ARVALID) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL prog_full_hold: got %0d arvalid cycles expected 0", seen);
      end
      @(posedge clk);
      #1;
      fifo_prog_full = 1'b0;
      @(negedge clk);
      checks++;
      if (M_AXI_ARVALID !== 1'b0) begin
         errors++;
         $display("FAIL prog_full_release_early: got %b expected 0", M_AXI_ARVALID);
      end
      @(negedge clk);
      checks++;
      if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== 32'h3C00 || M_AXI_ARLEN !== 8'd63) begin
         errors++;
         $display("FAIL prog_full_release: got %b %h %0d expected 1 3c00 63", M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN);
      end
      @(posedge clk);
      #1;
      wait_line_done();
      check_line_data();
   endtask

   task automatic test_rresp_err();
      clear_log(32'h5A00);
      err_addr = 32'h5B00;
      err_en   = 1'b1;
      checks++;
      if (rd_err !== 1'b0) begin
         errors++;
         $display("FAIL rd_err_before: got %b expected 0", rd_err);
      end
      do_request();
      wait_line_done();
      err_en = 1'b0;
      check_line_data();
      checks++;
      if (rd_err !== 1'b1) begin
         errors++;
         $display("FAIL rd_err_set: got %b expected 1", rd_err);
      end
      checks++;
      if (line_idx !== 11'd0) begin
         errors++;
         $display("FAIL line_wrap_idx: got %0d expected 0", line_idx);
      end
   endtask

   task automatic test_wrap();
      clear_log(32'h0);
      do_request();
      wait_line_done();
      check_line_data();
      checks++;
      if (ar_addr_q.size() > 0 && ar_addr_q[0] !== 32'h0) begin
         errors++;
         $display("FAIL wrap_araddr: got %h expected 0", ar_addr_q[0]);
      end
      checks++;
      if (line_idx !== 11'd1 || rd_err !== 1'b1) begin
         errors++;
         $display("FAIL wrap_after: got idx %0d err %b expected 1 1", line_idx, rd_err);
      end
   endtask

   task automatic test_fifo_rst();
      bit reached = 0;
      bit idle = 0;
      clear_log(32'h1E00);
      do_request();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (wr_count == 10) begin
            reached = 1;
            break;
         end
      end
      checks++;
      if (reached !== 1'b1) begin
         errors++;
         $display("FAIL rst_beat10_timeout: got %0d writes expected 10", wr_count);
      end
      @(posedge clk);
      #1;
      fifo_rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL rst_pulse_wr_en: got %b expected 0", fifo_wr_en);
      end
      @(posedge clk);
      #1;
      fifo_rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (line_idx !== 11'd0) begin
         errors++;
         $display("FAIL rst_line_idx: got %0d expected 0", line_idx);
      end
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (AXI_FULL_BURST_READY && !sl_busy) begin
            idle = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (idle !== 1'b1) begin
         errors++;
         $display("FAIL rst_drain_timeout: got busy expected idle");
      end
      checks++;
      if (wr_count !== 10 || ar_addr_q.size() !== 1) begin
         errors++;
         $display("FAIL rst_drop: got %0d writes %0d bursts expected 10 1", wr_count, ar_addr_q.size());
      end
      clear_log(32'h0);
      do_request();
      wait_line_done();
      check_line_data();
      checks++;
      if (ar_addr_q.size() > 0 && (ar_addr_q[0] !== 32'h0 || ar_len_q[0] !== 8'd63)) begin
         errors++;
         $display("FAIL rst_next_ar: got %h/%0d expected 0/63", ar_addr_q[0], ar_len_q[0]);
      end
   endtask

   task automatic test_aresetn_clear();
      checks++;
      if (rd_err !== 1'b1) begin
         errors++;
         $display("FAIL rd_err_sticky: got %b expected 1", rd_err);
      end
      M_AXI_ARESETN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      M_AXI_ARESETN = 1'b1;
      @(negedge clk);
      checks++;
      if (rd_err !== 1'b0 || line_idx !== 11'd0) begin
         errors++;
         $display("FAIL aresetn_clear: got err %b idx %0d expected 0 0", rd_err, line_idx);
      end
   endtask

   initial begin
      M_AXI_ARESETN        = 1'b0;
      AXI_FULL_BURST_VALID = 1'b0;
      fifo_rst_n           = 1'b1;
      fifo_prog_full       = 1'b0;
      err_en               = 1'b0;
      err_addr             = '0;
      wr_count             = 0;
      data_err             = 0;
      exp_addr             = '0;
      test_reset();
      test_line0();
      test_4k_split();
      test_prog_full();
      test_rresp_err();
      test_wrap();
      test_fifo_rst();
      test_aresetn_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
